// File: rtl/msrh_stq_drain_ctrl.sv
// Store-queue drain controller: picks the oldest committed store, reads the L1D line, and writes or refills via the LRQ.
// Optional hit/miss/conflict counters are built when MSRH_STQ_DRAIN_PERF_EN is defined.
module msrh_stq_drain_ctrl #(
    parameter int STQ_SIZE      = 16,
    parameter int PADDR_W       = 56,
    parameter int DCACHE_DATA_W = 128,
    parameter int LRQ_SIZE      = 8
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic [STQ_SIZE-1:0]          i_cmt_req,
    input  logic [$clog2(STQ_SIZE)-1:0]  i_head_ptr,
    output logic [STQ_SIZE-1:0]          o_grant_oh,
    input  logic [PADDR_W-1:0]           i_sel_paddr,
    input  logic [1:0]                   i_sel_size,
    input  logic [63:0]                  i_sel_data,
    output logic                         o_l1d_rd_valid,
    output logic [PADDR_W-1:0]           o_l1d_rd_paddr,
    input  logic                         i_l1d_rd_hit,
    input  logic                         i_l1d_rd_miss,
    input  logic                         i_l1d_rd_conflict,
    output logic                         o_l1d_wr_valid,
    output logic [PADDR_W-1:0]           o_l1d_wr_paddr,
    output logic [DCACHE_DATA_W-1:0]     o_l1d_wr_data,
    output logic [DCACHE_DATA_W/8-1:0]   o_l1d_wr_be,
    input  logic                         i_l1d_wr_conflict,
    output logic                         o_lrq_load,
    output logic [PADDR_W-1:0]           o_lrq_paddr,
    input  logic                         i_lrq_full,
    input  logic                         i_lrq_conflict,
    input  logic [LRQ_SIZE-1:0]          i_lrq_index_oh,
    input  logic                         i_lrq_resolve_valid,
    input  logic [LRQ_SIZE-1:0]          i_lrq_resolve_oh,
    output logic [STQ_SIZE-1:0]          o_done_oh,
    output logic                         o_busy,
    output logic [31:0]                  o_perf_hit,
    output logic [31:0]                  o_perf_miss,
    output logic [31:0]                  o_perf_conflict
);

    localparam int HEAD_W = $clog2(STQ_SIZE);
    localparam int BE_W   = DCACHE_DATA_W / 8;
    localparam int OFF_W  = $clog2(BE_W);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, WRITE, MISS_REQ, WAIT_REFILL
    } state_t;

    state_t                state;
    logic [STQ_SIZE-1:0]   grant_q;
    logic [PADDR_W-1:0]    paddr_q;
    logic [1:0]            size_q;
    logic [63:0]           data_q;
    logic [LRQ_SIZE-1:0]   lrq_idx_q;
    logic [STQ_SIZE-1:0]   pick_oh;
    logic                  early_resolve;

    function automatic logic [PADDR_W-1:0] line_align(input logic [PADDR_W-1:0] pa);
        logic [PADDR_W-1:0] r;
        r            = pa;
        r[OFF_W-1:0] = '0;
        return r;
    endfunction

    function automatic logic [STQ_SIZE-1:0] pick_oldest(input logic [STQ_SIZE-1:0] req,
                                                        input logic [HEAD_W-1:0]   head);
        logic [STQ_SIZE-1:0] oh;
        logic [HEAD_W-1:0]   idx;
        logic                found;
        oh    = '0;
        found = 1'b0;
        for (int k = 0; k < STQ_SIZE; k++) begin
            idx = head + HEAD_W'(k);
            if (!found && req[idx]) begin
                oh[idx] = 1'b1;
                found   = 1'b1;
            end
        end
        return oh;
    endfunction

    function automatic logic [DCACHE_DATA_W-1:0] replicate(input logic [63:0] d,
                                                           input logic [1:0]  sz);
        logic [DCACHE_DATA_W-1:0] r;
        int                       nb;
        nb = 1 << sz;
        r  = '0;
        for (int i = 0; i < BE_W; i++) begin
            r[8*i +: 8] = d[8*(i % nb) +: 8];
        end
        return r;
    endfunction

    // Bytes past the end of the slice are dropped rather than wrapped.
    function automatic logic [BE_W-1:0] byte_en(input logic [OFF_W-1:0] off,
                                                 input logic [1:0]      sz);
        logic [BE_W-1:0] r;
        int              lo;
        int              hi;
        lo = int'(off);
        hi = lo + (1 << sz);
        for (int i = 0; i < BE_W; i++) begin
            r[i] = (i >= lo) && (i < hi);
        end
        return r;
    endfunction

    assign pick_oh       = pick_oldest(i_cmt_req, i_head_ptr);
    assign early_resolve = i_lrq_resolve_valid && |(i_lrq_resolve_oh & i_lrq_index_oh);
    assign o_busy        = (state != IDLE);

    always_comb begin
        o_grant_oh     = '0;
        o_l1d_rd_valid = 1'b0;
        o_l1d_rd_paddr = '0;
        o_l1d_wr_valid = 1'b0;
        o_l1d_wr_paddr = '0;
        o_l1d_wr_data  = '0;
        o_l1d_wr_be    = '0;
        o_lrq_load     = 1'b0;
        o_lrq_paddr    = '0;
        o_done_oh      = '0;
        case (state)
            IDLE: begin
                // Grant is combinational off i_cmt_req, so mask it while reset is held.
                if (i_reset_n && |i_cmt_req) begin
                    o_grant_oh     = pick_oh;
                    o_l1d_rd_valid = 1'b1;
                    o_l1d_rd_paddr = line_align(i_sel_paddr);
                end
            end
            RD_REQ: begin
                o_l1d_rd_valid = 1'b1;
                o_l1d_rd_paddr = line_align(paddr_q);
            end
            WRITE: begin
                o_l1d_wr_valid = 1'b1;
                o_l1d_wr_paddr = line_align(paddr_q);
                o_l1d_wr_data  = replicate(data_q, size_q);
                o_l1d_wr_be    = byte_en(paddr_q[OFF_W-1:0], size_q);
                if (!i_l1d_wr_conflict) begin
                    o_done_oh = grant_q;
                end
            end
            MISS_REQ: begin
                o_lrq_load  = 1'b1;
                o_lrq_paddr = line_align(paddr_q);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            grant_q   <= '0;
            paddr_q   <= '0;
            size_q    <= '0;
            data_q    <= '0;
            lrq_idx_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|i_cmt_req) begin
                        grant_q <= pick_oh;
                        paddr_q <= i_sel_paddr;
                        size_q  <= i_sel_size;
                        data_q  <= i_sel_data;
                        state   <= RD_WAIT;
                    end
                end
                RD_REQ: state <= RD_WAIT;
                RD_WAIT: begin
                    if (i_l1d_rd_conflict) begin
                        state <= RD_REQ;
                    end else if (i_l1d_rd_hit) begin
                        state <= WRITE;
                    end else if (i_l1d_rd_miss) begin
                        state <= MISS_REQ;
                    end
                end
                WRITE: begin
                    if (!i_l1d_wr_conflict) begin
                        state <= IDLE;
                    end
                end
                MISS_REQ: begin
                    case ({i_lrq_full, i_lrq_conflict})
                        // Fresh allocation or merge into an entry already fetching this line.
                        2'b00, 2'b01: begin
                            lrq_idx_q <= i_lrq_index_oh;
                            state     <= early_resolve ? RD_REQ : WAIT_REFILL;
                        end
                        default: ;
                    endcase
                end
                WAIT_REFILL: begin
                    if (i_lrq_resolve_valid && |(i_lrq_resolve_oh & lrq_idx_q)) begin
                        state <= RD_REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MSRH_STQ_DRAIN_PERF_EN
    logic [31:0] perf_hit_q;
    logic [31:0] perf_miss_q;
    logic [31:0] perf_conflict_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    // One outcome per lookup, with the same priority the FSM applies.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            perf_hit_q      <= '0;
            perf_miss_q     <= '0;
            perf_conflict_q <= '0;
        end else if (state == RD_WAIT) begin
            if (i_l1d_rd_conflict) begin
                perf_conflict_q <= sat_inc(perf_conflict_q);
            end else if (i_l1d_rd_hit) begin
                perf_hit_q <= sat_inc(perf_hit_q);
            end else if (i_l1d_rd_miss) begin
                perf_miss_q <= sat_inc(perf_miss_q);
            end
        end
    end

    assign o_perf_hit      = perf_hit_q;
    assign o_perf_miss     = perf_miss_q;
    assign o_perf_conflict = perf_conflict_q;
`else
    assign o_perf_hit      = '0;
    assign o_perf_miss     = '0;
    assign o_perf_conflict = '0;
`endif

endmodule

// File: tb/tb_msrh_stq_drain_ctrl.sv
// Directed bench for msrh_stq_drain_ctrl: each task drives one scenario and checks its outputs inline.
`timescale 1ns/1ps
module tb_msrh_stq_drain_ctrl;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   cmt_req;
    logic [3:0]    head_ptr;
    logic [15:0]   grant_oh;
    logic [55:0]   sel_paddr;
    logic [1:0]    sel_size;
    logic [63:0]   sel_data;
    logic          rd_valid;
    logic [55:0]   rd_paddr;
    logic          rd_hit, rd_miss, rd_conflict;
    logic          wr_valid;
    logic [55:0]   wr_paddr;
    logic [127:0]  wr_data;
    logic [15:0]   wr_be;
    logic          wr_conflict;
    logic          lrq_load;
    logic [55:0]   lrq_paddr;
    logic          lrq_full, lrq_conflict;
    logic [7:0]    lrq_index_oh;
    logic          resolve_valid;
    logic [7:0]    resolve_oh;
    logic [15:0]   done_oh;
    logic          busy;
    logic [31:0]   perf_hit, perf_miss, perf_conflict;

    int errors = 0;
    int checks = 0;

`ifdef MSRH_STQ_DRAIN_PERF_EN
    localparam logic [31:0] EXP_HIT  = 32'd1;
    localparam logic [31:0] EXP_CONF = 32'd2;
`else
    localparam logic [31:0] EXP_HIT  = 32'd0;
    localparam logic [31:0] EXP_CONF = 32'd0;
`endif

    always #5 clk = ~clk;

    msrh_stq_drain_ctrl dut (
        .i_clk               (clk),
        .i_reset_n           (rst_n),
        .i_cmt_req           (cmt_req),
        .i_head_ptr          (head_ptr),
        .o_grant_oh          (grant_oh),
        .i_sel_paddr         (sel_paddr),
        .i_sel_size          (sel_size),
        .i_sel_data          (sel_data),
        .o_l1d_rd_valid      (rd_valid),
        .o_l1d_rd_paddr      (rd_paddr),
        .i_l1d_rd_hit        (rd_hit),
        .i_l1d_rd_miss       (rd_miss),
        .i_l1d_rd_conflict   (rd_conflict),
        .o_l1d_wr_valid      (wr_valid),
        .o_l1d_wr_paddr      (wr_paddr),
        .o_l1d_wr_data       (wr_data),
        .o_l1d_wr_be         (wr_be),
        .i_l1d_wr_conflict   (wr_conflict),
        .o_lrq_load          (lrq_load),
        .o_lrq_paddr         (lrq_paddr),
        .i_lrq_full          (lrq_full),
        .i_lrq_conflict      (lrq_conflict),
        .i_lrq_index_oh      (lrq_index_oh),
        .i_lrq_resolve_valid (resolve_valid),
        .i_lrq_resolve_oh    (resolve_oh),
        .o_done_oh           (done_oh),
        .o_busy              (busy),
        .o_perf_hit          (perf_hit),
        .o_perf_miss         (perf_miss),
        .o_perf_conflict     (perf_conflict)
    );

    task automatic clear_inputs();
        cmt_req       = '0;
        rd_hit        = 1'b0;
        rd_miss       = 1'b0;
        rd_conflict   = 1'b0;
        wr_conflict   = 1'b0;
        lrq_full      = 1'b0;
        lrq_conflict  = 1'b0;
        lrq_index_oh  = '0;
        resolve_valid = 1'b0;
        resolve_oh    = '0;
    endtask

    // Advance to the next falling edge with all pulse inputs deasserted.
    task automatic next_cyc();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic issue(input logic [15:0] req, input logic [3:0] head, input logic [55:0] pa,
                         input logic [1:0] sz, input logic [63:0] d);
        next_cyc();
        cmt_req   = req;
        head_ptr  = head;
        sel_paddr = pa;
        sel_size  = sz;
        sel_data  = d;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        head_ptr  = '0;
        sel_paddr = '0;
        sel_size  = '0;
        sel_data  = '0;
        rst_n     = 1'b0;
        cmt_req   = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        checks++; if (grant_oh !== 16'h0) begin errors++; $display("FAIL rst_grant got=%h exp=0000", grant_oh); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got=%0h exp=0", rd_valid); end
        checks++; if (wr_valid !== 1'b0 || lrq_load !== 1'b0) begin errors++; $display("FAIL rst_wr_lrq got=%0h/%0h exp=0/0", wr_valid, lrq_load); end
        checks++; if (done_oh !== 16'h0) begin errors++; $display("FAIL rst_done got=%h exp=0000", done_oh); end
        checks++; if ({perf_hit, perf_miss, perf_conflict} !== 96'h0) begin errors++; $display("FAIL rst_perf got=%0d/%0d/%0d exp=0/0/0", perf_hit, perf_miss, perf_conflict); end
        next_cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        issue(16'h0010, 4'd0, 56'h0000_1000_0123, 2'd2, 64'h1122_3344_5566_7788);
        checks++; if (grant_oh !== 16'h0010) begin errors++; $display("FAIL basic_grant got=%h exp=0010", grant_oh); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_rd_valid got=%0h exp=1", rd_valid); end
        checks++; if (rd_paddr !== 56'h0000_1000_0120) begin errors++; $display("FAIL basic_rd_paddr got=%h exp=00000010000120", rd_paddr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy0 got=%0h exp=0", busy); end
        next_cyc();
        cmt_req   = 16'h0010;
        sel_paddr = '1;
        sel_data  = '0;
        rd_hit    = 1'b1;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy1 got=%0h exp=1", busy); end
        checks++; if (grant_oh !== 16'h0 || rd_valid !== 1'b0) begin errors++; $display("FAIL basic_wait_idle got=%h/%0h exp=0000/0", grant_oh, rd_valid); end
        next_cyc();
        #1;
        checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL basic_wr_valid got=%0h exp=1", wr_valid); end
        checks++; if (done_oh !== 16'h0010) begin errors++; $display("FAIL basic_done got=%h exp=0010", done_oh); end
        checks++; if (wr_be !== 16'h0078) begin errors++; $display("FAIL basic_wr_be got=%h exp=0078", wr_be); end
        checks++; if (wr_data !== {4{32'h5566_7788}}) begin errors++; $display("FAIL basic_wr_data got=%h exp=%h", wr_data, {4{32'h5566_7788}}); end
        issue(16'h0100, 4'd0, 56'h0000_0000_2000, 2'd0, 64'h0);
        checks++; if (busy !== 1'b0 || done_oh !== 16'h0) begin errors++; $display("FAIL b2b_idle got=%0h/%h exp=0/0000", busy, done_oh); end
        checks++; if (grant_oh !== 16'h0100) begin errors++; $display("FAIL b2b_grant got=%h exp=0100", grant_oh); end
        next_cyc();
        rd_hit = 1'b1;
        next_cyc();
        #1;
        checks++; if (done_oh !== 16'h0100) begin errors++; $display("FAIL b2b_done got=%h exp=0100", done_oh); end
        next_cyc();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy got=%0h exp=0", busy); end
    endtask

    task automatic test_wrap();
        issue(16'h8003, 4'd14, 56'h0000_0000_2000, 2'd0, 64'h0000_0000_0000_00A5);
        checks++; if (grant_oh !== 16'h8000) begin errors++; $display("FAIL wrap14_grant got=%h exp=8000", grant_oh); end
        next_cyc();
        rd_hit = 1'b1;
        next_cyc();
        #1;
        checks++; if (done_oh !== 16'h8000) begin errors++; $display("FAIL wrap14_done got=%h exp=8000", done_oh); end
        checks++; if (wr_be !== 16'h0001 || wr_data !== {16{8'hA5}}) begin errors++; $display("FAIL wrap14_byte got=%h/%h exp=0001/a5..", wr_be, wr_data); end
        issue(16'h0006, 4'd15, 56'h0000_0000_2100, 2'd0, 64'h0);
        checks++; if (grant_oh !== 16'h0002) begin errors++; $display("FAIL wrap15_grant got=%h exp=0002", grant_oh); end
        next_cyc();
        rd_hit = 1'b1;
        next_cyc();
        #1;
        checks++; if (done_oh !== 16'h0002) begin errors++; $display("FAIL wrap15_done got=%h exp=0002", done_oh); end
    endtask

    task automatic test_sizes();
        logic [55:0]  pa   [3];
        logic [1:0]   sz   [3];
        logic [63:0]  d    [3];
        logic [15:0]  be   [3];
        logic [127:0] wd   [3];
        pa[0] = 56'h4006; sz[0] = 2'd1; d[0] = 64'hDEAD_0000_0000_BEEF; be[0] = 16'h00C0; wd[0] = {8{16'hBEEF}};
        pa[1] = 56'h5008; sz[1] = 2'd3; d[1] = 64'h0123_4567_89AB_CDEF; be[1] = 16'hFF00; wd[1] = {2{64'h0123_4567_89AB_CDEF}};
        pa[2] = 56'h600F; sz[2] = 2'd0; d[2] = 64'hFFFF_FFFF_FFFF_FF5A; be[2] = 16'h8000; wd[2] = {16{8'h5A}};
        for (int v = 0; v < 3; v++) begin
            issue(16'h0001, 4'd0, pa[v], sz[v], d[v]);
            next_cyc();
            rd_hit = 1'b1;
            next_cyc();
            #1;
            checks++; if (wr_be !== be[v]) begin errors++; $display("FAIL size%0d_be got=%h exp=%h", v, wr_be, be[v]); end
            checks++; if (wr_data !== wd[v]) begin errors++; $display("FAIL size%0d_data got=%h exp=%h", v, wr_data, wd[v]); end
        end
        next_cyc();
    endtask

    task automatic test_miss_refill();
        issue(16'h0004, 4'd0, 56'h0000_0000_3048, 2'd3, 64'hCAFE_F00D_1234_5678);
        next_cyc();
        rd_miss = 1'b1;
        #1;
        checks++; if (busy !== 1'b1 || lrq_load !== 1'b0) begin errors++; $display("FAIL miss_wait got=%0h/%0h exp=1/0", busy, lrq_load); end
        next_cyc();
        lrq_full = 1'b1;
        #1;
        checks++; if (lrq_load !== 1'b1) begin errors++; $display("FAIL miss_load1 got=%0h exp=1", lrq_load); end
        checks++; if (lrq_paddr !== 56'h0000_0000_3040) begin errors++; $display("FAIL miss_lrq_paddr got=%h exp=00000000003040", lrq_paddr); end
        next_cyc();
        lrq_full = 1'b1;
        #1;
        checks++; if (lrq_load !== 1'b1) begin errors++; $display("FAIL miss_load2 got=%0h exp=1", lrq_load); end
        next_cyc();
        lrq_index_oh = 8'h04;
        #1;
        checks++; if (lrq_load !== 1'b1) begin errors++; $display("FAIL miss_load3 got=%0h exp=1", lrq_load); end
        next_cyc();
        resolve_valid = 1'b1;
        resolve_oh    = 8'h02;
        #1;
        checks++; if (lrq_load !== 1'b0 || rd_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL refill_wait got=%0h/%0h/%0h exp=0/0/1", lrq_load, rd_valid, busy); end
        next_cyc();
        resolve_valid = 1'b1;
        resolve_oh    = 8'h04;
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL refill_wrong_idx got=%0h exp=0", rd_valid); end
        next_cyc();
        #1;
        checks++; if (rd_valid !== 1'b1 || rd_paddr !== 56'h0000_0000_3040) begin errors++; $display("FAIL reread got=%0h/%h exp=1/00000000003040", rd_valid, rd_paddr); end
        checks++; if (grant_oh !== 16'h0) begin errors++; $display("FAIL reread_grant got=%h exp=0000", grant_oh); end
        next_cyc();
        rd_hit = 1'b1;
        next_cyc();
        #1;
        checks++; if (done_oh !== 16'h0004 || wr_valid !== 1'b1) begin errors++; $display("FAIL miss_done got=%h/%0h exp=0004/1", done_oh, wr_valid); end
        next_cyc();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL miss_end_busy got=%0h exp=0", busy); end
    endtask

    task automatic test_early_resolve();
        issue(16'h0020, 4'd0, 56'h0000_0000_A000, 2'd2, 64'h0);
        next_cyc();
        rd_miss = 1'b1;
        next_cyc();
        lrq_conflict  = 1'b1;
        lrq_index_oh  = 8'h10;
        resolve_valid = 1'b1;
        resolve_oh    = 8'h10;
        next_cyc();
        #1;
        checks++; if (rd_valid !== 1'b1 || rd_paddr !== 56'h0000_0000_A000) begin errors++; $display("FAIL early_resolve got=%0h/%h exp=1/0000000000a000", rd_valid, rd_paddr); end
        next_cyc();
        rd_hit = 1'b1;
        next_cyc();
        #1;
        checks++; if (done_oh !== 16'h0020) begin errors++; $display("FAIL early_done got=%h exp=0020", done_oh); end
        next_cyc();
    endtask

    task automatic test_conflicts();
        logic rc [9];
        logic rh [9];
        logic wc [9];
        int   reads  = 0;
        int   writes = 0;
        int   dones  = 0;
        logic [15:0] seen = '0;
        // Cycle 0 issue; 1 conflict+hit; 2 reread; 3 conflict; 4 reread; 5 hit; 6 wr conflict; 7 write; 8 idle.
        for (int c = 0; c < 9; c++) begin rc[c] = 1'b0; rh[c] = 1'b0; wc[c] = 1'b0; end
        rc[1] = 1'b1; rh[1] = 1'b1; rc[3] = 1'b1; rh[5] = 1'b1; wc[6] = 1'b1;
        next_cyc();
        rst_n = 1'b0;
        #1;
        next_cyc();
        rst_n = 1'b1;
        issue(16'h0200, 4'd9, 56'h0000_0000_7010, 2'd2, 64'h0);
        for (int c = 0; c < 9; c++) begin
            if (c > 0) begin
                next_cyc();
                rd_conflict = rc[c];
                rd_hit      = rh[c];
                wr_conflict = wc[c];
                #1;
            end
            if (rd_valid === 1'b1) reads++;
            if (wr_valid === 1'b1) writes++;
            if (done_oh !== 16'h0) begin dones++; seen = done_oh; end
        end
        checks++; if (reads != 3) begin errors++; $display("FAIL conf_reads got=%0d exp=3", reads); end
        checks++; if (writes != 2) begin errors++; $display("FAIL conf_writes got=%0d exp=2", writes); end
        checks++; if (dones != 1 || seen !== 16'h0200) begin errors++; $display("FAIL conf_done got=%0d/%h exp=1/0200", dones, seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL conf_end_busy got=%0h exp=0", busy); end
        checks++; if (perf_conflict !== EXP_CONF) begin errors++; $display("FAIL perf_conflict got=%0d exp=%0d", perf_conflict, EXP_CONF); end
        checks++; if (perf_hit !== EXP_HIT) begin errors++; $display("FAIL perf_hit got=%0d exp=%0d", perf_hit, EXP_HIT); end
        checks++; if (perf_miss !== 32'd0) begin errors++; $display("FAIL perf_miss got=%0d exp=0", perf_miss); end
    endtask

    task automatic test_reset_mid();
        issue(16'h0001, 4'd0, 56'h0000_0000_8000, 2'd2, 64'h0);
        next_cyc();
        rd_miss = 1'b1;
        next_cyc();
        lrq_index_oh = 8'h01;
        next_cyc();
        cmt_req = 16'h0008;
        #1;
        checks++; if (busy !== 1'b1 || lrq_load !== 1'b0) begin errors++; $display("FAIL mid_refill got=%0h/%0h exp=1/0", busy, lrq_load); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%0h exp=0", busy); end
        checks++; if (grant_oh !== 16'h0 || rd_valid !== 1'b0 || wr_valid !== 1'b0 || lrq_load !== 1'b0 || done_oh !== 16'h0) begin
            errors++; $display("FAIL mid_rst_outs got=%h/%0h/%0h/%0h/%h exp=0", grant_oh, rd_valid, wr_valid, lrq_load, done_oh);
        end
        next_cyc();
        rst_n = 1'b1;
        issue(16'h0008, 4'd0, 56'h0000_0000_9004, 2'd0, 64'h11);
        checks++; if (grant_oh !== 16'h0008 || rd_valid !== 1'b1) begin errors++; $display("FAIL post_rst_grant got=%h/%0h exp=0008/1", grant_oh, rd_valid); end
        next_cyc();
        rd_hit = 1'b1;
        next_cyc();
        #1;
        checks++; if (done_oh !== 16'h0008 || wr_be !== 16'h0010) begin errors++; $display("FAIL post_rst_done got=%h/%h exp=0008/0010", done_oh, wr_be); end
        next_cyc();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_sizes();
        test_miss_refill();
        test_early_resolve();
        test_conflicts();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
